l1_d_cache_ctrl: RTL and testbench

Direct-mapped L1 data-cache controller that sequences the 64-set × 512-bit L1 data array. It holds the tag, valid and dirty arrays and accepts one core load/store at a time. It drives the array's index/offset/update/refill controls and runs the L2 writeback/refill handshake on a miss. Hit/miss performance counters are included.

---
 rtl/l1_d_cache_ctrl_if.sv | 28 ++
 rtl/l1_d_cache_ctrl.sv | 136 +++++++++++++
 tb/tb_l1_d_cache_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/l1_d_cache_ctrl_if.sv
// rtl/l1_d_cache_ctrl_if.sv - core, data-array and L2 signal bundle for the L1 D-cache controller
interface l1_d_cache_ctrl_if;
    logic        core_req_valid;
    logic        core_req_write;
    logic [31:0] core_req_addr;
    logic        core_ready;
    logic        core_resp_valid;
    logic [5:0]  arr_index;
    logic [5:0]  arr_offset;
    logic        arr_update;
    logic        arr_refill;
    logic        l2_req;
    logic        l2_write;
    logic [31:0] l2_addr;
    logic        l2_ack;

    modport slave (
        input  core_req_valid, core_req_write, core_req_addr, l2_ack,
        output core_ready, core_resp_valid, arr_index, arr_offset,
               arr_update, arr_refill, l2_req, l2_write, l2_addr
    );

    modport master (
        output core_req_valid, core_req_write, core_req_addr, l2_ack,
        input  core_ready, core_resp_valid, arr_index, arr_offset,
               arr_update, arr_refill, l2_req, l2_write, l2_addr
    );
endinterface

// File: rtl/l1_d_cache_ctrl.sv
// rtl/l1_d_cache_ctrl.sv - direct-mapped L1 D-cache controller with tag/valid/dirty state and L2 writeback/refill
module l1_d_cache_ctrl #(
    parameter int SETS  = 64,
    parameter int TAG_W = 20,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    l1_d_cache_ctrl_if.slave bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int IDX_W = $clog2(SETS);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        RESP
    } state_t;

    state_t                       state_q, state_d;
    logic [31:0]                  addr_q, addr_d;
    logic                         write_q, write_d;
    logic [SETS-1:0]              valid_q, valid_d;
    logic [SETS-1:0]              dirty_q, dirty_d;
    logic [SETS-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]             hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]             miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;

    assign idx     = addr_q[6 +: IDX_W];
    assign req_tag = addr_q[31 -: TAG_W];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            valid_q    <= '0;
            dirty_q    <= '0;
            tag_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            tag_q      <= tag_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        bus.core_ready      = 1'b0;
        bus.core_resp_valid = 1'b0;
        bus.arr_update      = 1'b0;
        bus.arr_refill      = 1'b0;
        bus.l2_req          = 1'b0;
        bus.l2_write        = 1'b0;
        bus.l2_addr         = '0;

        unique case (state_q)
            IDLE: begin
                bus.core_ready = 1'b1;
                if (bus.core_req_valid) begin
                    addr_d  = bus.core_req_addr;
                    write_d = bus.core_req_write;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    if (write_q) begin
                        bus.arr_update = 1'b1;
                        dirty_d[idx]   = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                // Victim address comes from the stored tag, not the request
                bus.l2_req   = 1'b1;
                bus.l2_write = 1'b1;
                bus.l2_addr  = {tag_q[idx], idx, 6'b0};
                if (bus.l2_ack) begin
                    dirty_d[idx] = 1'b0;
                    state_d      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.l2_req  = 1'b1;
                bus.l2_addr = {req_tag, idx, 6'b0};
                if (bus.l2_ack) begin
                    // L2 data is only valid during the ack cycle, so refill is combinational
                    bus.arr_refill = 1'b1;
                    tag_d[idx]     = req_tag;
                    valid_d[idx]   = 1'b1;
                    dirty_d[idx]   = 1'b0;
                    state_d        = COMPARE;
                end
            end
            RESP: begin
                bus.core_resp_valid = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.arr_index  = addr_q[11:6];
    assign bus.arr_offset = addr_q[5:0];
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;
endmodule

// File: tb/tb_l1_d_cache_ctrl.sv
// tb/tb_l1_d_cache_ctrl.sv - directed self-checking bench for l1_d_cache_ctrl
module tb_l1_d_cache_ctrl;
    logic        clk;
    logic        nrst;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    int          tests;
    int          fails;

    l1_d_cache_ctrl_if bus();

    l1_d_cache_ctrl #(.SETS(64), .TAG_W(20), .CNT_W(16)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and let combinational outputs settle
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr);
        @(negedge clk);
        bus.core_req_valid = 1'b1;
        bus.core_req_addr  = addr;
        bus.core_req_write = wr;
        @(negedge clk);
        bus.core_req_valid = 1'b0;
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        nrst  = 1'b0;
        bus.core_req_valid = 1'b0;
        bus.core_req_write = 1'b0;
        bus.core_req_addr  = '0;
        bus.l2_ack         = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", bus.core_ready, 1);
        check("rst_l2_req", bus.l2_req, 0);
        check("rst_l2_addr", bus.l2_addr, 0);
        check("rst_resp", bus.core_resp_valid, 0);
        check("rst_index", bus.arr_index, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_miss", miss_cnt, 0);
        nrst = 1'b1;

        // Cold load miss
        issue(32'h0000_1040, 1'b0);
        check("cold_cmp_ready", bus.core_ready, 0);
        check("cold_cmp_index", bus.arr_index, 1);
        check("cold_cmp_l2_req", bus.l2_req, 0);
        step();
        check("cold_alloc_miss", miss_cnt, 1);
        check("cold_alloc_req", bus.l2_req, 1);
        check("cold_alloc_wr", bus.l2_write, 0);
        check("cold_alloc_addr", bus.l2_addr, 32'h0000_1040);
        check("cold_alloc_refill0", bus.arr_refill, 0);
        bus.l2_ack = 1'b1;
        #1;
        check("cold_refill", bus.arr_refill, 1);
        check("cold_refill_upd", bus.arr_update, 0);
        @(negedge clk);
        bus.l2_ack = 1'b0;
        #1;
        check("cold_recmp_req", bus.l2_req, 0);
        check("cold_recmp_refill", bus.arr_refill, 0);
        step();
        check("cold_resp", bus.core_resp_valid, 1);
        check("cold_hit", hit_cnt, 1);
        step();
        check("cold_idle_resp", bus.core_resp_valid, 0);
        check("cold_idle_ready", bus.core_ready, 1);

        // Load hit, two-cycle latency
        issue(32'h0000_1044, 1'b0);
        check("lhit_cmp_resp", bus.core_resp_valid, 0);
        check("lhit_offset", bus.arr_offset, 4);
        check("lhit_cmp_req", bus.l2_req, 0);
        step();
        check("lhit_resp", bus.core_resp_valid, 1);
        check("lhit_resp_req", bus.l2_req, 0);
        check("lhit_hit", hit_cnt, 2);
        check("lhit_miss", miss_cnt, 1);

        // Store hit
        issue(32'h0000_1048, 1'b1);
        check("st_update", bus.arr_update, 1);
        check("st_refill", bus.arr_refill, 0);
        check("st_offset", bus.arr_offset, 8);
        step();
        check("st_update_off", bus.arr_update, 0);
        check("st_resp", bus.core_resp_valid, 1);
        check("st_hit", hit_cnt, 3);

        // Dirty eviction
        issue(32'h0000_2040, 1'b0);
        check("ev_cmp_update", bus.arr_update, 0);
        step();
        check("ev_wb_req", bus.l2_req, 1);
        check("ev_wb_wr", bus.l2_write, 1);
        check("ev_wb_addr", bus.l2_addr, 32'h0000_1040);
        check("ev_wb_miss", miss_cnt, 2);
        bus.l2_ack = 1'b1;
        #1;
        check("ev_wb_refill", bus.arr_refill, 0);
        @(negedge clk);
        bus.l2_ack = 1'b0;
        #1;
        check("ev_al_req", bus.l2_req, 1);
        check("ev_al_wr", bus.l2_write, 0);
        check("ev_al_addr", bus.l2_addr, 32'h0000_2040);
        bus.l2_ack = 1'b1;
        #1;
        check("ev_al_refill", bus.arr_refill, 1);
        @(negedge clk);
        bus.l2_ack = 1'b0;
        step();
        check("ev_resp", bus.core_resp_valid, 1);
        check("ev_hit", hit_cnt, 4);
        check("ev_miss", miss_cnt, 2);

        // Clean eviction plus L2 stall with a busy core
        issue(32'h0000_3040, 1'b0);
        step();
        check("cl_al_wr", bus.l2_write, 0);
        check("cl_al_addr", bus.l2_addr, 32'h0000_3040);
        check("cl_miss", miss_cnt, 3);
        bus.core_req_valid = 1'b1;
        bus.core_req_addr  = 32'h0000_5084;
        bus.core_req_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_req", bus.l2_req, 1);
            check("stall_addr", bus.l2_addr, 32'h0000_3040);
            check("stall_ready", bus.core_ready, 0);
            check("stall_index", bus.arr_index, 1);
        end
        bus.core_req_valid = 1'b0;
        bus.l2_ack = 1'b1;
        #1;
        check("stall_refill", bus.arr_refill, 1);
        @(negedge clk);
        bus.l2_ack = 1'b0;
        #1;
        check("stall_recmp_update", bus.arr_update, 0);
        step();
        check("stall_resp", bus.core_resp_valid, 1);
        check("stall_hit", hit_cnt, 5);
        check("stall_offset", bus.arr_offset, 0);

        // Reset in the middle of ALLOCATE
        issue(32'h0000_1040, 1'b0);
        step();
        check("mid_al_req", bus.l2_req, 1);
        nrst = 1'b0;
        #1;
        check("mid_rst_req", bus.l2_req, 0);
        check("mid_rst_hit", hit_cnt, 0);
        check("mid_rst_miss", miss_cnt, 0);
        check("mid_rst_ready", bus.core_ready, 1);
        @(negedge clk);
        nrst = 1'b1;
        issue(32'h0000_3040, 1'b0);
        step();
        check("post_rst_req", bus.l2_req, 1);
        check("post_rst_addr", bus.l2_addr, 32'h0000_3040);
        check("post_rst_miss", miss_cnt, 1);
        bus.l2_ack = 1'b1;
        @(negedge clk);
        bus.l2_ack = 1'b0;
        step();
        check("post_rst_resp", bus.core_resp_valid, 1);
        check("post_rst_hit", hit_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
